// File: rtl/hex_mon_pkg.sv
// Shared types and ASCII constants for the hex stream monitor.
package hex_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StSep,
    StCr,
    StLf
  } state_e;

  localparam logic [7:0] AsciiSp     = 8'h20;
  localparam logic [7:0] AsciiCr     = 8'h0D;
  localparam logic [7:0] AsciiLf     = 8'h0A;
  localparam logic [7:0] AsciiZero   = 8'h30;
  localparam logic [7:0] AsciiUpperA = 8'h41;
  localparam logic [7:0] AsciiLowerA = 8'h61;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational nibble to ASCII hex digit, upper or lower case letters.
module nibble_to_ascii
  import hex_mon_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       lower,
  output logic [7:0] ch
);

  always_comb begin
    if (nibble < 4'd10) begin
      ch = AsciiZero + {4'b0000, nibble};
    end else begin
      ch = (lower ? AsciiLowerA : AsciiUpperA) + {4'b0000, nibble - 4'd10};
    end
  end

endmodule

// File: rtl/hex_stream_monitor.sv
// Hex-dump formatter: NB-byte words in, ASCII hex + separator / CR LF out to a UART TX FIFO.
module hex_stream_monitor
  import hex_mon_pkg::*;
#(
  parameter int unsigned NB  = 1,
  parameter int unsigned WPL = 16,
  parameter logic [7:0]  SEP = 8'h20
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [8*NB-1:0] in_data,
  input  logic            lower_case,
  input  logic            line_flush,
  input  logic            tx_full,
  output logic            wr_uart,
  output logic [7:0]      w_data,
  output logic            busy
);

  localparam int unsigned BiW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WcW = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [BiW-1:0] BiLast = BiW'(NB - 1);
  localparam logic [WcW-1:0] WcLast = WcW'(WPL - 1);

  state_e             state_q, state_d;
  logic [8*NB-1:0]    data_q, data_d;
  logic               lower_q, lower_d;
  logic [BiW-1:0]     byte_idx_q, byte_idx_d;
  logic [WcW-1:0]     word_cnt_q, word_cnt_d;
  logic [7:0]         cur_byte;
  logic [3:0]         nibble;
  logic [7:0]         hex_char;

  assign cur_byte = data_q[{byte_idx_q, 3'b000} +: 8];
  assign nibble   = (state_q == StHi) ? cur_byte[7:4] : cur_byte[3:0];

  nibble_to_ascii u_nibble_to_ascii (
    .nibble (nibble),
    .lower  (lower_q),
    .ch     (hex_char)
  );

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    lower_d    = lower_q;
    byte_idx_d = byte_idx_q;
    word_cnt_d = word_cnt_q;
    in_ready   = 1'b0;
    wr_uart    = 1'b0;
    w_data     = AsciiSp;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        // A pending flush wins over a simultaneously offered word.
        if (line_flush && (word_cnt_q != '0)) begin
          word_cnt_d = '0;
          state_d    = StCr;
        end else if (in_valid) begin
          data_d     = in_data;
          lower_d    = lower_case;
          byte_idx_d = BiLast;
          state_d    = StHi;
        end
      end
      StHi: begin
        w_data  = hex_char;
        wr_uart = !tx_full;
        if (wr_uart) state_d = StLo;
      end
      StLo: begin
        w_data  = hex_char;
        wr_uart = !tx_full;
        if (wr_uart) begin
          if (byte_idx_q == '0) begin
            state_d = StSep;
          end else begin
            byte_idx_d = byte_idx_q - 1'b1;
            state_d    = StHi;
          end
        end
      end
      StSep: begin
        if ((WPL != 0) && (word_cnt_q == WcLast)) begin
          // Line end: CR LF replaces the separator.
          word_cnt_d = '0;
          state_d    = StCr;
        end else begin
          w_data  = SEP;
          wr_uart = !tx_full;
          if (wr_uart) begin
            if (WPL != 0) word_cnt_d = word_cnt_q + 1'b1;
            state_d = StIdle;
          end
        end
      end
      StCr: begin
        w_data  = AsciiCr;
        wr_uart = !tx_full;
        if (wr_uart) state_d = StLf;
      end
      StLf: begin
        w_data  = AsciiLf;
        wr_uart = !tx_full;
        if (wr_uart) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      data_q     <= '0;
      lower_q    <= 1'b0;
      byte_idx_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      lower_q    <= lower_d;
      byte_idx_q <= byte_idx_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_hex_stream_monitor.sv
// Scoreboard bench: three monitor instances (NB=1/WPL=0, NB=2/WPL=16, NB=1/WPL=2).
module tb_hex_stream_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  in_valid = '0;
  logic [2:0]  lower_case = '0;
  logic [2:0]  line_flush = '0;
  logic [2:0]  tx_full = '0;
  logic [15:0] in_data [3];
  logic [2:0]  in_ready, wr_uart, busy;
  logic [7:0]  w_data [3];

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  logic [7:0] exp2 [$];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_stream_monitor #(.NB(1), .WPL(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][7:0]), .lower_case(lower_case[0]), .line_flush(line_flush[0]),
    .tx_full(tx_full[0]), .wr_uart(wr_uart[0]), .w_data(w_data[0]), .busy(busy[0])
  );

  hex_stream_monitor #(.NB(2), .WPL(16)) u1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .lower_case(lower_case[1]), .line_flush(line_flush[1]),
    .tx_full(tx_full[1]), .wr_uart(wr_uart[1]), .w_data(w_data[1]), .busy(busy[1])
  );

  hex_stream_monitor #(.NB(1), .WPL(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][7:0]), .lower_case(lower_case[2]), .line_flush(line_flush[2]),
    .tx_full(tx_full[2]), .wr_uart(wr_uart[2]), .w_data(w_data[2]), .busy(busy[2])
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int k, input logic [7:0] b);
    case (k)
      0: exp0.push_back(b);
      1: exp1.push_back(b);
      default: exp2.push_back(b);
    endcase
  endtask

  task automatic pop_cmp(input int k, input logic [7:0] act);
    logic [7:0] e;
    bit have;
    have = 1'b0;
    e = 8'h00;
    case (k)
      0: if (exp0.size() != 0) begin e = exp0.pop_front(); have = 1'b1; end
      1: if (exp1.size() != 0) begin e = exp1.pop_front(); have = 1'b1; end
      default: if (exp2.size() != 0) begin e = exp2.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL unexpected_write dut%0d actual=%h required=none", k, act);
    end else if (act !== e) begin
      failures++;
      $display("FAIL char dut%0d actual=%h required=%h", k, act, e);
    end
  endtask

  // Monitor: every write strobe is compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (wr_uart[k]) pop_cmp(k, w_data[k]);
      end
    end
  end

  // Returns one ns after the accepting edge, i.e. inside the HI cycle.
  task automatic send(input int k, input logic [15:0] d, input logic lc);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    in_valid[k] = 1'b1;
    in_data[k] = d;
    lower_case[k] = lc;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (in_ready[k]) done = 1'b1;
    end
    if (!done) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if (!busy[k]) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) in_data[k] = 16'h0000;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_wr", int'(wr_uart[k]), 0);
      check("rst_wdata", int'(w_data[k]), 'h20);
      check("rst_ready", int'(in_ready[k]), 1);
      check("rst_busy", int'(busy[k]), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;

    // A5 upper: three consecutive writes, then ready again.
    push(0, 8'h41); push(0, 8'h35); push(0, 8'h20);
    send(0, 16'h00A5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_wr_consecutive", int'(wr_uart[0]), 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t1_ready_back", int'(in_ready[0]), 1);
    check("t1_wr_idle", int'(wr_uart[0]), 0);

    // NB=2 lower case.
    push(1, 8'h31); push(1, 8'h63); push(1, 8'h33); push(1, 8'h66); push(1, 8'h20);
    send(1, 16'h1C3F, 1'b1);
    wait_idle(1);

    // WPL=2: second word ends the line with CR LF.
    push(2, 8'h30); push(2, 8'h30); push(2, 8'h20);
    push(2, 8'h46); push(2, 8'h46); push(2, 8'h0D); push(2, 8'h0A);
    send(2, 16'h0000, 1'b0);
    wait_idle(2);
    send(2, 16'h00FF, 1'b0);
    wait_idle(2);
    // word_cnt is 0 now, so a flush must do nothing.
    @(posedge clk); #1;
    line_flush[2] = 1'b1;
    @(posedge clk); #1;
    line_flush[2] = 1'b0;
    repeat (4) @(negedge clk);
    check("t3_flush_empty_busy", int'(busy[2]), 0);

    // Back-pressure in LO of 7E.
    push(0, 8'h37); push(0, 8'h45); push(0, 8'h20);
    send(0, 16'h007E, 1'b0);
    @(posedge clk); #1;
    tx_full[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_stall_wr", int'(wr_uart[0]), 0);
      check("t4_stall_wdata", int'(w_data[0]), 'h45);
      @(posedge clk); #1;
    end
    tx_full[0] = 1'b0;
    @(negedge clk);
    check("t4_release_wr", int'(wr_uart[0]), 1);
    wait_idle(0);

    // Flush with word_cnt=1 beats a simultaneous word; the word goes next IDLE.
    push(2, 8'h31); push(2, 8'h32); push(2, 8'h20);
    send(2, 16'h0012, 1'b0);
    wait_idle(2);
    push(2, 8'h0D); push(2, 8'h0A); push(2, 8'h33); push(2, 8'h34); push(2, 8'h20);
    @(posedge clk); #1;
    line_flush[2] = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2] = 16'h0034;
    @(negedge clk);
    check("t5_ready_during_flush", int'(in_ready[2]), 1);
    @(posedge clk); #1;
    line_flush[2] = 1'b0;
    @(negedge clk);
    check("t5_cr_ready", int'(in_ready[2]), 0);
    check("t5_cr_wdata", int'(w_data[2]), 'h0D);
    @(negedge clk);
    check("t5_lf_ready", int'(in_ready[2]), 0);
    @(negedge clk);
    check("t5_idle_ready", int'(in_ready[2]), 1);
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(negedge clk);
    check("t5_word_hi", int'(busy[2]), 1);
    wait_idle(2);

    // Reset after the HI char of BEEF discards the rest.
    push(1, 8'h42);
    send(1, 16'hBEEF, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_wr", int'(wr_uart[1]), 0);
    check("t6_rst_wdata", int'(w_data[1]), 'h20);
    check("t6_rst_busy", int'(busy[1]), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_post_ready", int'(in_ready[1]), 1);
    check("t6_post_busy", int'(busy[1]), 0);

    check("q0_drained", exp0.size(), 0);
    check("q1_drained", exp1.size(), 0);
    check("q2_drained", exp2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
